rand_seed_csr: RTL

RAND_SEED_CSR -- requirements
Module: rand_seed_csr

---
 rtl/rand_seed_csr.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/rand_seed_csr.sv
// rand_seed_csr: entropy seed CSR backend.
//
// Collects a per-hart random bit stream into 16-bit words, queues them in a
// small FIFO and serves them through a seed CSR read with side effect.
// After reset the first WARMUP valid bits are discarded (BIST). A shared
// failure flag forces a sticky DEAD state that only reset clears.
//
// Ports:
//   clk         single clock, rising edge
//   reset       synchronous, active-high
//   rand_valid  random-bit strobe
//   rand_data   random bit, qualified by rand_valid
//   rand_dead   entropy-source failure flag
//   seed_rd     one-cycle CSR read strobe (pops a word when one is queued)
//   seed_rdata  read value: [31:30] OPST, [29:16] zero, [15:0] entropy
//   seed_avail  high while at least one word is queued (OPST == ES16)
//   dbg_state   current OPST state, for observation
//
// Handshake: seed_rd is a single-cycle strobe with no back-pressure; the
// result appears on seed_rdata the cycle after and holds until the next
// seed_rd. rand_valid qualifies rand_data in the same cycle and is never
// stalled; a word that finds the FIFO full (and no pop that cycle) is lost.
module rand_seed_csr #(
  parameter int NWORDS = 4,
  parameter int WARMUP = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rand_valid,
  input  logic        rand_data,
  input  logic        rand_dead,
  input  logic        seed_rd,
  output logic [31:0] seed_rdata,
  output logic        seed_avail,
  output logic [1:0]  dbg_state
);

  localparam int PW = $clog2(NWORDS);
  localparam int CW = PW + 1;
  localparam int WW = $clog2(WARMUP + 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(NWORDS);
  localparam logic [WW-1:0] WARM_LAST = WW'(WARMUP - 1);

  typedef enum logic [1:0] {
    ST_BIST = 2'b00,
    ST_WAIT = 2'b01,
    ST_ES16 = 2'b10,
    ST_DEAD = 2'b11
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [WW-1:0]   r_warm;
  logic [14:0]     r_shreg;
  logic [3:0]      r_bitcnt;
  logic [15:0]     r_mem [NWORDS];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic [31:0]     r_rdata;

  logic            w_run;
  logic            w_pop;
  logic            w_word_done;
  logic            w_push;
  logic            w_warm_done;
  logic [CW-1:0]   w_count_nxt;
  logic [15:0]     w_word;

  assign w_run       = (r_state == ST_WAIT) || (r_state == ST_ES16);
  assign w_word      = {r_shreg, rand_data};
  // rand_dead overrides every queue operation in its cycle.
  assign w_pop       = seed_rd && (r_state == ST_ES16) && !rand_dead;
  assign w_word_done = w_run && rand_valid && (r_bitcnt == 4'd15);
  // A same-cycle pop frees a slot, so a full FIFO can still accept the word.
  assign w_push      = w_word_done && !rand_dead && ((r_count != FULL_CNT) || w_pop);
  assign w_warm_done = (r_state == ST_BIST) && rand_valid && (r_warm == WARM_LAST);
  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

  // Next-state logic; WAIT/ES16 simply track whether the FIFO will be non-empty.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_BIST: if (w_warm_done) w_state_nxt = ST_WAIT;
      ST_WAIT,
      ST_ES16: w_state_nxt = (w_count_nxt != '0) ? ST_ES16 : ST_WAIT;
      ST_DEAD: w_state_nxt = ST_DEAD;
      default: w_state_nxt = ST_BIST;
    endcase
    if (rand_dead) w_state_nxt = ST_DEAD;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_BIST;
      r_warm   <= '0;
      r_shreg  <= '0;
      r_bitcnt <= '0;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_rdata  <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (seed_rd) begin
        if (rand_dead || (r_state == ST_DEAD))
          r_rdata <= 32'hC000_0000;
        else
          r_rdata <= {r_state, 14'b0, (r_state == ST_ES16) ? r_mem[r_rptr] : 16'h0000};
      end

      if (rand_dead) begin
        r_shreg  <= '0;
        r_bitcnt <= '0;
        r_wptr   <= '0;
        r_rptr   <= '0;
        r_count  <= '0;
      end else begin
        if ((r_state == ST_BIST) && rand_valid)
          r_warm <= r_warm + 1'b1;
        if (w_run && rand_valid) begin
          r_shreg  <= w_word[14:0];
          r_bitcnt <= r_bitcnt + 4'd1;
        end
        if (w_push) r_wptr <= r_wptr + 1'b1;
        if (w_pop)  r_rptr <= r_rptr + 1'b1;
        r_count <= w_count_nxt;
      end
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (!reset && w_push) r_mem[r_wptr] <= w_word;
  end

  assign seed_rdata = r_rdata;
  assign seed_avail = (r_state == ST_ES16);
  assign dbg_state  = r_state;

endmodule
